// File: rtl/amber_wb_pkg.sv
// Shared types for the Amber Wishbone responder: NOP filler word,
// responder FSM states and the store record written to the result monitor.
package amber_wb_pkg;

  localparam logic [31:0] WB_FILLER = 32'hF080_1003;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_resp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wb_store_rec_t;

endpackage

// File: rtl/amber_sync_fifo.sv
// Synchronous FIFO with head-of-queue read data and an occupancy count.
// Zero read latency; a push while full or a pop while empty is ignored.
module amber_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count, so a same-cycle pop never frees space for a push.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone slave for the Amber core: serves fetches from a loaded FIFO, reports stores.
// Ack/err WAIT_CYCLES+1 cycles after the request edge; one request in flight, pushes stall when full.
module amber_wb_responder
  import amber_wb_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0001_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            wb_adr,
  input  logic [15:0]            wb_sel,
  input  logic                   wb_we,
  input  logic [127:0]           wb_dat_w,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  output logic [127:0]           wb_dat_r,
  output logic                   wb_ack,
  output logic                   wb_err,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_inst,
  output logic                   ld_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   st_valid,
  output logic [31:0]            st_addr,
  output logic [31:0]            st_data,
  output logic [3:0]             st_sel
);

  wb_resp_state_t state;
  logic [3:0]     wait_cnt;
  logic [31:0]    adr_q;
  logic [15:0]    sel_q;
  logic           we_q;
  logic [127:0]   dat_w_q;
  wb_store_rec_t  st_rec;

  logic           in_range;
  logic [1:0]     lane;
  logic           fifo_pop;
  logic [31:0]    fifo_head;
  logic           fifo_full;
  logic           fifo_empty;

  assign in_range = (adr_q < ADDR_LIMIT);
  assign lane     = adr_q[3:2];
  assign fifo_pop = (state == RESP) && in_range && !we_q;
  assign ld_ready = ~fifo_full;

  assign st_addr  = st_rec.addr;
  assign st_data  = st_rec.data;
  assign st_sel   = st_rec.sel;

  amber_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_valid),
    .push_dat (ld_inst),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      dat_w_q  <= '0;
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      st_valid <= 1'b0;
      wb_dat_r <= '0;
      st_rec   <= '0;
    end else begin
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      st_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc && wb_stb) begin
            adr_q    <= wb_adr;
            sel_q    <= wb_sel;
            we_q     <= wb_we;
            dat_w_q  <= wb_dat_w;
            wait_cnt <= 4'(WAIT_CYCLES);
            state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          // Out-of-range accesses leave read data, FIFO and store record untouched.
          if (!in_range) begin
            wb_err <= 1'b1;
          end else begin
            wb_ack <= 1'b1;
            if (we_q) begin
              st_valid    <= 1'b1;
              st_rec.addr <= {adr_q[31:2], 2'b00};
              st_rec.data <= dat_w_q[{lane, 5'b00000} +: 32];
              st_rec.sel  <= sel_q[{lane, 2'b00} +: 4];
            end else if (fifo_empty) begin
              wb_dat_r <= {4{WB_FILLER}};
            end else begin
              wb_dat_r <= {{3{WB_FILLER}}, fifo_head};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder with a response scoreboard and FIFO model.
module tb_amber_wb_responder;
  import amber_wb_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          W     = 2;
  localparam logic [31:0] LIMIT = 32'h0001_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wb_adr;
  logic [15:0]  wb_sel;
  logic         wb_we;
  logic [127:0] wb_dat_w;
  logic         wb_cyc;
  logic         wb_stb;
  logic [127:0] wb_dat_r;
  logic         wb_ack;
  logic         wb_err;
  logic         ld_valid;
  logic [31:0]  ld_inst;
  logic         ld_ready;
  logic [4:0]   fifo_count;
  logic         st_valid;
  logic [31:0]  st_addr;
  logic [31:0]  st_data;
  logic [3:0]   st_sel;

  always #5 clk = ~clk;

  amber_wb_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W),
    .ADDR_LIMIT  (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_we      (wb_we),
    .wb_dat_w   (wb_dat_w),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_dat_r   (wb_dat_r),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .ld_valid   (ld_valid),
    .ld_inst    (ld_inst),
    .ld_ready   (ld_ready),
    .fifo_count (fifo_count),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_sel     (st_sel)
  );

  typedef struct {
    logic         err;
    logic [127:0] dat;
    logic         st_v;
    logic [31:0]  st_a;
    logic [31:0]  st_d;
    logic [3:0]   st_s;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  model_q[$];
  logic [127:0] last_dat;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    ld_inst  = v;
    ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(v);
  endtask

  task automatic do_req(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                        input logic [127:0] dat);
    exp_t e;
    exp_t got;
    int   lat;
    lat   = 0;
    e.err = (adr >= LIMIT);
    e.dat = last_dat;
    e.st_v = 1'b0;
    e.st_a = '0;
    e.st_d = '0;
    e.st_s = '0;
    if (!e.err && we) begin
      e.st_v = 1'b1;
      e.st_a = {adr[31:2], 2'b00};
      e.st_d = dat[32*int'(adr[3:2]) +: 32];
      e.st_s = sel[4*int'(adr[3:2]) +: 4];
    end else if (!e.err) begin
      if (model_q.size() > 0) e.dat = {{3{WB_FILLER}}, model_q.pop_front()};
      else                    e.dat = {4{WB_FILLER}};
    end
    exp_q.push_back(e);

    wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_w = dat;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (wb_ack || wb_err) begin
        lat = k;
        break;
      end
    end
    ld_valid = 1'b0;

    got = exp_q.pop_front();
    check("latency", 128'(lat), 128'(W + 1));
    check("ack", 128'(wb_ack), 128'(!got.err));
    check("err", 128'(wb_err), 128'(got.err));
    check("dat_r", wb_dat_r, got.dat);
    check("st_valid", 128'(st_valid), 128'(got.st_v));
    if (got.st_v) begin
      check("st_addr", 128'(st_addr), 128'(got.st_a));
      check("st_data", 128'(st_data), 128'(got.st_d));
      check("st_sel", 128'(st_sel), 128'(got.st_s));
    end
    last_dat = got.dat;
    @(posedge clk); #1;
    check("one_cycle_pulse", 128'({wb_ack, wb_err, st_valid}), 128'(0));
    check("fifo_count", 128'(fifo_count), 128'(model_q.size()));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat_w = '0;
    wb_cyc = 1'b0; wb_stb = 1'b0; ld_valid = 1'b0; ld_inst = '0;
    last_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_ack", 128'(wb_ack), 128'(0));
    check("rst_err", 128'(wb_err), 128'(0));
    check("rst_st_valid", 128'(st_valid), 128'(0));
    check("rst_dat_r", wb_dat_r, 128'(0));
    check("rst_st_addr", 128'({st_addr, st_data, st_sel}), 128'(0));
    check("rst_fifo_count", 128'(fifo_count), 128'(0));
    check("rst_ld_ready", 128'(ld_ready), 128'(1));

    // Fetch one loaded instruction, then fetch from an empty FIFO.
    push(32'hE3A0_1005);
    check("count_after_push", 128'(fifo_count), 128'(1));
    do_req(32'h0000_0000, 1'b0, 16'hFFFF, '0);
    do_req(32'h0000_0010, 1'b0, 16'hFFFF, '0);

    // Stores on two different lanes.
    do_req(32'h0000_0108, 1'b1, 16'h0F00, 128'h1111_1111_DEAD_BEEF_2222_2222_3333_3333);
    do_req(32'h0000_0204, 1'b1, 16'h00A0, 128'h4444_4444_5555_5555_CAFE_F00D_6666_6666);
    check("st_addr_hold", 128'(st_addr), 128'(32'h0000_0204));

    // Out-of-range read leaves the loaded entry in place.
    push(32'hA5A5_0001);
    do_req(32'h0001_0000, 1'b0, 16'hFFFF, '0);
    do_req(32'h0000_0020, 1'b0, 16'hFFFF, '0);

    // Fill the FIFO; a push during the popping read is dropped.
    for (int i = 0; i < DEPTH; i++) push(32'h1000_0000 + 32'(i));
    check("full_count", 128'(fifo_count), 128'(DEPTH));
    check("full_ld_ready", 128'(ld_ready), 128'(0));
    ld_inst  = 32'hBAD0_0017;
    ld_valid = 1'b1;
    do_req(32'h0000_0030, 1'b0, 16'hFFFF, '0);
    check("ld_ready_after_pop", 128'(ld_ready), 128'(1));
    do_req(32'h0000_0040, 1'b0, 16'hFFFF, '0);

    // Reset in the middle of a wait period.
    push(32'h7777_0000);
    wb_adr = 32'h0000_0050; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    last_dat = '0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (wb_ack || wb_err) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_resp", 128'(seen), 128'(0));
    check("abort_count", 128'(fifo_count), 128'(0));
    check("abort_ld_ready", 128'(ld_ready), 128'(1));
    do_req(32'h0000_0060, 1'b0, 16'hFFFF, '0);
    push(32'h0BAD_CAFE);
    do_req(32'h0000_0064, 1'b0, 16'hFFFF, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
